// File: rtl/neuron_bist.sv
// neuron_bist: LFSR-driven vector launcher and response checker for the digital neuron.
// Latency: D/STB register one CK after each strobe cycle; the response to vector n is compared at strobe n+1.
// Backpressure: none; one vector every DIV CK cycles while running, START ignored until the run ends.
//
// Ports:
//   CK, RSTB            - neuron clock (rising edge) and asynchronous active-low reset
//   START               - level-sampled run request (acts in IDLE and DONE only)
//   Q, Q_EXP            - neuron output and its expected value, sampled only in strobe cycles
//   D, STB              - packed inputs D0..D7 (D0 = D[7:0]) and the one-CK launch pulse
//   BUSY, DONE          - state indicators
//   PASS_CNT, FAIL_CNT  - saturating compare counters
//   FIRST_FAIL          - vector index of the first mismatching compare, 0 if none
module neuron_bist #(
  parameter int          DIV      = 10,
  parameter int          NUM_VECT = 256,
  parameter logic [63:0] SEED     = 64'h0000_0000_0000_0001,
  parameter int          CW       = 16
) (
  input  logic          CK,
  input  logic          RSTB,
  input  logic          START,
  input  logic [7:0]    Q,
  input  logic [7:0]    Q_EXP,
  output logic [63:0]   D,
  output logic          STB,
  output logic          BUSY,
  output logic          DONE,
  output logic [CW-1:0] PASS_CNT,
  output logic [CW-1:0] FAIL_CNT,
  output logic [CW-1:0] FIRST_FAIL
);

  localparam int DW = $clog2(DIV);
  localparam int VW = $clog2(NUM_VECT + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [VW-1:0] NV       = VW'(NUM_VECT);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [63:0]   lfsr;
  logic [DW-1:0] div_cnt;
  logic [VW-1:0] vect_cnt;

  logic          start_run;
  logic          strobe;
  logic          do_cmp;
  logic          do_launch;
  logic          last_strobe;
  logic          mismatch;
  logic          lfsr_fb;
  logic [CW-1:0] k_sat;

  // Strobe-cycle decode. vect_cnt is the index k of the strobe: k>=1 carries a
  // compare for the vector launched at the previous strobe, k<NUM_VECT launches
  // a new vector, k==NUM_VECT is the final compare-only strobe.
  always_comb begin
    start_run   = START && (state != ST_RUN);
    strobe      = (state == ST_RUN) && (div_cnt == DIV_LAST);
    do_cmp      = strobe && (vect_cnt != '0);
    do_launch   = strobe && (vect_cnt < NV);
    last_strobe = strobe && (vect_cnt == NV);
    mismatch    = (Q != Q_EXP);
    lfsr_fb     = lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59];
  end

  // FIRST_FAIL saturates like the counters when the vector index outgrows CW.
  always_comb begin
    k_sat = CNT_MAX;
    if (64'(vect_cnt) < 64'(CNT_MAX)) begin
      k_sat = CW'(vect_cnt);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (START)       state_nxt = ST_RUN;
      ST_RUN:  if (last_strobe) state_nxt = ST_DONE;
      ST_DONE: if (START)       state_nxt = ST_RUN;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge RSTB) begin
    if (!RSTB) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign BUSY = (state == ST_RUN);
  assign DONE = (state == ST_DONE);

  always_ff @(posedge CK or negedge RSTB) begin
    if (!RSTB) begin
      lfsr       <= SEED;
      div_cnt    <= '0;
      vect_cnt   <= '0;
      D          <= '0;
      STB        <= 1'b0;
      PASS_CNT   <= '0;
      FAIL_CNT   <= '0;
      FIRST_FAIL <= '0;
    end else begin
      STB <= 1'b0;
      if (start_run) begin
        lfsr       <= SEED;
        div_cnt    <= '0;
        vect_cnt   <= '0;
        PASS_CNT   <= '0;
        FAIL_CNT   <= '0;
        FIRST_FAIL <= '0;
      end else if (state == ST_RUN) begin
        lfsr <= {lfsr[62:0], lfsr_fb};

        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end

        // The final strobe leaves vect_cnt at NUM_VECT so it cannot overflow
        // VW bits; the next START reloads it anyway.
        if (strobe && !last_strobe) begin
          vect_cnt <= vect_cnt + VW'(1);
        end

        if (do_launch) begin
          D   <= lfsr;
          STB <= 1'b1;
        end

        if (do_cmp) begin
          if (mismatch) begin
            if (FAIL_CNT == '0) begin
              FIRST_FAIL <= k_sat;
            end
            if (FAIL_CNT != CNT_MAX) begin
              FAIL_CNT <= FAIL_CNT + CW'(1);
            end
          end else if (PASS_CNT != CNT_MAX) begin
            PASS_CNT <= PASS_CNT + CW'(1);
          end
        end
      end
    end
  end

endmodule
